// File: rtl/mem_burst_if.sv
// Command, write-beat and read-beat handshake bundle for mem_burst_controller.
interface mem_burst_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_BITS-1:0]  cmd_addr;
    logic [ADDR_BITS-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  busy;

    // Producer/consumer side (decoder and datapath).
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/mem_burst_controller.sv
// Burst memory controller: owns a 2**ADDR_BITS x DATA_WIDTH register-file RAM and
// runs single/burst WRITE, burst READ and whole-array CLEAR commands.
module mem_burst_controller #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 4
) (
    input  logic       clock,
    input  logic       reset,
    mem_burst_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  addr_ptr;
    logic [ADDR_BITS-1:0]  beats_left;
    logic                  issue_done;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  cmd_ready_q;
    logic                  busy_q;
    logic                  wr_ready_q;

    logic                  cmd_acc_c;
    logic                  wr_acc_c;
    logic                  rd_load_c;
    logic                  rd_last_c;
    logic                  ptr_inc_c;
    logic                  mem_we_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_nxt   = state;
        cmd_acc_c   = 1'b0;
        wr_acc_c    = 1'b0;
        rd_load_c   = 1'b0;
        rd_last_c   = 1'b0;
        ptr_inc_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_acc_c = 1'b1;
                    case (bus.cmd_op)
                        OP_NOP:   state_nxt = ST_IDLE;
                        OP_WRITE: state_nxt = ST_WRITE;
                        OP_READ:  state_nxt = ST_READ;
                        OP_CLEAR: state_nxt = ST_CLEAR;
                    endcase
                end
            end
            ST_WRITE: begin
                if (bus.wr_valid) begin
                    wr_acc_c    = 1'b1;
                    ptr_inc_c   = 1'b1;
                    mem_we_c    = 1'b1;
                    mem_wdata_c = bus.wr_data;
                    if (beats_left == '0) state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                // Refill while beats remain to be issued and the output slot frees up.
                rd_load_c = !issue_done && (!rd_valid_q || bus.rd_ready);
                rd_last_c = issue_done && rd_valid_q && bus.rd_ready;
                ptr_inc_c = rd_load_c;
                if (rd_last_c) state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                mem_we_c  = 1'b1;
                ptr_inc_c = 1'b1;
                if (addr_ptr == '1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pointer, beat counter, read output register and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_ptr    <= '0;
            beats_left  <= '0;
            issue_done  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            if (cmd_acc_c) begin
                addr_ptr   <= (bus.cmd_op == OP_CLEAR) ? '0 : bus.cmd_addr;
                beats_left <= bus.cmd_len;
                issue_done <= 1'b0;
            end else if (ptr_inc_c) begin
                addr_ptr <= addr_ptr + ADDR_BITS'(1);
            end
            if (wr_acc_c || rd_load_c) begin
                if (beats_left == '0) issue_done <= 1'b1;
                else                  beats_left <= beats_left - ADDR_BITS'(1);
            end
            if (rd_load_c) begin
                rd_data_q  <= mem[addr_ptr];
                rd_valid_q <= 1'b1;
            end else if (rd_last_c) begin
                rd_valid_q <= 1'b0;
            end
            cmd_ready_q <= (state_nxt == ST_IDLE);
            busy_q      <= (state_nxt != ST_IDLE);
            wr_ready_q  <= (state_nxt == ST_WRITE);
        end
    end

    // Register-file RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_c) mem[addr_ptr] <= mem_wdata_c;
    end
endmodule

// File: tb/tb_mem_burst_controller.sv
// Self-checking bench for mem_burst_controller against a behavioural memory model.
module tb_mem_burst_controller;
    localparam int unsigned DW    = 8;
    localparam int unsigned AB    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BOUND = 300;

    logic clock;
    logic reset;

    mem_burst_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

    mem_burst_controller #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];

    logic [DW-1:0] wr_q[$];
    bit            wpat[$];
    bit            rpat[$];
    int unsigned   wr_gap_pct   = 0;
    int unsigned   rd_stall_pct = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input int addr, input int len);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) begin
            checks++;
            failures++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = AB'(addr);
        bus.cmd_len   = AB'(len);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
    endtask

    task automatic do_write(input int addr, input int len);
        int beat = 0;
        int cyc  = 0;
        bit v;
        bit acc;
        send_cmd(2'd1, addr, len);
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_ready_first: got %b required 1", bus.wr_ready);
        end
        while (beat <= len && cyc < BOUND) begin
            if (wpat.size() > 0) v = wpat.pop_front();
            else                 v = ($urandom_range(99) >= wr_gap_pct);
            bus.wr_valid = v;
            bus.wr_data  = v ? wr_q[beat] : DW'($urandom);
            acc = v && (bus.wr_ready === 1'b1);
            tick();
            cyc++;
            if (acc) begin
                ref_mem[(addr + beat) % DEPTH]   = wr_q[beat];
                ref_known[(addr + beat) % DEPTH] = 1'b1;
                beat++;
            end
        end
        bus.wr_valid = 1'b0;
        wpat.delete();
        if (beat <= len) begin
            checks++;
            failures++;
            $display("FAIL write_timeout: beats accepted %0d required %0d", beat, len + 1);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_done: busy=%b cmd_ready=%b wr_ready=%b required 0 1 0",
                     bus.busy, bus.cmd_ready, bus.wr_ready);
        end
    endtask

    task automatic do_read(input int addr, input int len, input bit check_first);
        int got = 0;
        int cyc = 0;
        bit r;
        bit prev_hold = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] exp;
        send_cmd(2'd2, addr, len);
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL read_enter: rd_valid=%b wr_ready=%b busy=%b required 0 0 1",
                     bus.rd_valid, bus.wr_ready, bus.busy);
        end
        while (got <= len && cyc < BOUND) begin
            if (rpat.size() > 0) r = rpat.pop_front();
            else                 r = ($urandom_range(99) >= rd_stall_pct);
            bus.rd_ready = r;
            if (prev_hold) begin
                checks++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== prev_data) begin
                    failures++;
                    $display("FAIL rd_hold: rd_valid=%b rd_data=%h required 1 %h",
                             bus.rd_valid, bus.rd_data, prev_data);
                end
            end
            if (check_first && cyc == 1) begin
                checks++;
                if (bus.rd_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rd_first: rd_valid=%b required 1", bus.rd_valid);
                end
            end
            if (bus.rd_valid === 1'b1 && r) begin
                exp = ref_mem[(addr + got) % DEPTH];
                if (ref_known[(addr + got) % DEPTH]) begin
                    checks++;
                    if (bus.rd_data !== exp) begin
                        failures++;
                        $display("FAIL rd_beat: addr %0d got %h required %h",
                                 (addr + got) % DEPTH, bus.rd_data, exp);
                    end
                end
                got++;
            end
            prev_hold = (bus.rd_valid === 1'b1) && !r;
            prev_data = bus.rd_data;
            tick();
            cyc++;
        end
        bus.rd_ready = 1'b0;
        rpat.delete();
        if (got <= len) begin
            checks++;
            failures++;
            $display("FAIL read_timeout: beats consumed %0d required %0d", got, len + 1);
        end
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL read_done: rd_valid=%b busy=%b cmd_ready=%b required 0 0 1",
                     bus.rd_valid, bus.busy, bus.cmd_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0 ||
            bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
            failures++;
            $display("FAIL %s: cmd_ready=%b busy=%b wr_ready=%b rd_valid=%b rd_data=%h required 1 0 0 0 00",
                     tag, bus.cmd_ready, bus.busy, bus.wr_ready, bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        check_reset_outputs("reset_state");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("reset_idle");
    endtask

    task automatic test_single();
        wr_q = '{8'hA5};
        do_write(3, 0);
        rpat = '{1'b1, 1'b1};
        do_read(3, 0, 1'b1);
    endtask

    task automatic test_wrap();
        wr_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_write(14, 3);
        do_read(14, 3, 1'b1);
        checks++;
        if (ref_mem[0] !== 8'h33) begin
            failures++;
            $display("FAIL wrap_model: got %h required 33", ref_mem[0]);
        end
        do_read(0, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        rpat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_read(14, 3, 1'b0);
    endtask

    task automatic test_write_gaps();
        wr_q = '{8'h01, 8'h02, 8'h03};
        wpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_write(5, 2);
        do_read(5, 2, 1'b1);
    endtask

    task automatic test_clear();
        wr_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) wr_q.push_back(8'hFF);
        do_write(0, 15);
        send_cmd(2'd3, 0, 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL clear_busy: cycle %0d busy=%b cmd_ready=%b rd_valid=%b required 1 0 0",
                         i, bus.busy, bus.cmd_ready, bus.rd_valid);
            end
            tick();
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_done: busy=%b cmd_ready=%b required 0 1", bus.busy, bus.cmd_ready);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b1;
        end
        do_read(0, 15, 1'b1);
    endtask

    task automatic test_reset_mid();
        wr_q = '{8'h3C};
        do_write(10, 0);
        send_cmd(2'd1, 8, 3);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hAA;
        tick();
        bus.wr_data  = 8'hBB;
        tick();
        ref_mem[8] = 8'hAA;
        ref_mem[9] = 8'hBB;
        bus.wr_data = 8'hEE;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        tick();
        tick();
        reset        = 1'b0;
        bus.wr_valid = 1'b0;
        tick();
        do_read(8, 1, 1'b1);
        do_read(8, 3, 1'b0);
    endtask

    task automatic test_nop();
        send_cmd(2'd0, $urandom_range(15), $urandom_range(15));
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL nop: busy=%b cmd_ready=%b wr_ready=%b required 0 1 0",
                     bus.busy, bus.cmd_ready, bus.wr_ready);
        end
    endtask

    task automatic test_random();
        int unsigned op;
        int addr;
        int len;
        wr_gap_pct   = 30;
        rd_stall_pct = 35;
        for (int it = 0; it < 30; it++) begin
            op   = $urandom_range(9);
            addr = $urandom_range(15);
            len  = $urandom_range(15);
            if (op < 4) begin
                wr_q.delete();
                for (int i = 0; i <= len; i++) wr_q.push_back(DW'($urandom));
                do_write(addr, len);
            end else if (op < 8) begin
                do_read(addr, len, 1'b0);
            end else begin
                test_nop();
            end
        end
        wr_gap_pct   = 0;
        rd_stall_pct = 0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        bus.rd_ready  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_write_gaps();
        test_clear();
        test_reset_mid();
        test_nop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_burst_controller.md
# mem_burst_controller

Parametrised successor to the single-beat memory controller. It owns an internal 2**ADDR_BITS x DATA_WIDTH register-file RAM and executes single or burst write, burst read and whole-array clear commands. Commands arrive over a valid/ready command port, write beats over a valid/ready write port, and read beats leave through a registered valid/ready read port. It sits between the instruction decoder and the datapath.

## Interface
- DATA_WIDTH, 8, word width in bits (>=1)
- ADDR_BITS, 4, address width; depth = 2**ADDR_BITS (>=1)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  2  0 NOP, 1 WRITE, 2 READ, 3 CLEAR
- cmd_addr  in  ADDR_BITS  burst start address; ignored for NOP/CLEAR
- cmd_len  in  ADDR_BITS  beats minus one (0 = 1 beat); ignored for NOP/CLEAR
- wr_data  in  DATA_WIDTH  write beat data
- wr_valid  in  1  write beat present
- wr_ready  out  1  write beat accepted when wr_valid & wr_ready
- rd_data  out  DATA_WIDTH  registered read beat data
- rd_valid  out  1  read beat present
- rd_ready  in  1  consumer takes beat when rd_valid & rd_ready
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, WRITE, READ, CLEAR.
- Command accept: cmd_valid & cmd_ready at a clock edge. The edge latches addr_ptr=cmd_addr and beats_left=cmd_len. The FSM enters the op's state next cycle.
- NOP: accepted; FSM stays in IDLE; no other effect.
- WRITE:
  - wr_ready=1 for the whole state.
  - Each accepted beat writes mem[addr_ptr]=wr_data at that edge.
  - addr_ptr increments modulo 2**ADDR_BITS (wraps from max to 0).
  - beats_left decrements.
  - The beat accepted with beats_left==0 is the last; the FSM returns to IDLE.
  - Cycles with wr_valid=0 are not counted.
- READ:
  - Output register loads rd_data=mem[addr_ptr] and sets rd_valid=1 when (issue beats remain) & (!rd_valid | rd_ready).
  - addr_ptr wraps as for WRITE.
  - While rd_valid & !rd_ready, rd_data and rd_valid hold stable. No beat is lost or duplicated.
  - The FSM returns to IDLE in the same edge the last beat is consumed; rd_valid goes 0 there.
  - wr_ready=0.
- CLEAR: writes 0 to addresses 0..2**ADDR_BITS-1, one per cycle in ascending order, then returns to IDLE. wr_ready=0; rd_valid=0.
- wr_ready=0 and rd_valid=0 in IDLE.
- Memory contents are not reset. They are undefined until written or cleared.
- A READ reads values written by any earlier completed WRITE or CLEAR.
- Length arithmetic: beats = cmd_len+1, max 2**ADDR_BITS. A full-length burst touches every address exactly once.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state IDLE, cmd_ready=1, busy=0
  - wr_ready=0, rd_valid=0, rd_data=0
  - addr_ptr=0, beats_left=0
- Reset mid-operation: aborts the op. No further memory writes occur. Beats written before reset keep their values.
- WRITE: first beat can be accepted 1 cycle after command accept. Throughput is 1 beat/cycle. Next command can be accepted 1 cycle after the last beat.
- READ: rd_valid first rises 2 edges after command accept, i.e. 1 cycle after entering READ. With rd_ready held high, throughput is 1 beat/cycle.
- CLEAR: busy for exactly 2**ADDR_BITS cycles after accept. cmd_ready=1 on the following cycle.
- Simultaneous events:
  - A command presented during busy is not accepted; the producer must hold it.
  - In READ, a consume and a refill on the same edge are legal and keep rd_valid=1.

## Test plan
- Single write then read (DATA_WIDTH=8, ADDR_BITS=4): WRITE addr 3, len 0, data 0xA5; then READ addr 3, len 0 -> rd_valid=1 two edges after read accept with rd_data=0xA5; busy=0 after the beat is consumed.
- Wrap-around burst: WRITE addr 14, len 3, data 0x11,0x22,0x33,0x44 -> stored at 14,15,0,1. READ addr 14, len 3 -> 0x11,0x22,0x33,0x44 in order. READ addr 0, len 0 -> 0x33.
- Backpressure: READ len 3 of the above with rd_ready pattern 0,1,0,1,1,0,1 -> exactly 4 beats consumed in order; rd_data stable while rd_valid & !rd_ready.
- Write gaps: WRITE addr 5, len 2 with wr_valid 1,0,0,1,0,1 carrying 0x01,x,x,0x02,x,0x03 -> mem[5..7]=0x01,0x02,0x03; IDLE after the third valid beat.
- Clear: fill all 16 entries with 0xFF, issue CLEAR -> busy=1 for 16 cycles, cmd_ready=0 throughout. READ addr 0, len 15 returns sixteen 0x00.
- Reset mid-burst: WRITE addr 8, len 3; assert reset asynchronously after 2 beats (0xAA,0xBB) -> outputs immediately at reset values. After release, READ addr 8, len 1 returns 0xAA,0xBB; mem[10] is unchanged from its prior value.
